// File: rtl/streaming_fifo_pkg.sv
// rtl/streaming_fifo_pkg.sv - shared sizing and parameter-sanity helpers for streaming_fifo_param
// Purpose: width helpers for pointers/occupancy and the threshold check used at elaboration.
// Ports: none (package).
package streaming_fifo_pkg;

   // Bits needed to encode the values 0..n-1 (at least 1 bit).
   function automatic int clog2_depth(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

   // Occupancy counts 0..depth inclusive, so it needs one more code than a pointer.
   function automatic int count_width(input int depth);
      return clog2_depth(depth + 1);
   endfunction

   // Thresholds must be ordered so the two flags can never both be meaningless.
   function automatic bit thresholds_ok(input int depth, input int afull_th, input int aempty_th);
      return (depth >= 2) && (aempty_th >= 0) && (aempty_th < afull_th) && (afull_th <= depth);
   endfunction

endpackage

// File: rtl/streaming_fifo_param_if.sv
// rtl/streaming_fifo_param_if.sv - stream handshake bundle (tdata/tvalid/tready)
// Purpose: groups one stream channel; master drives data/valid, slave drives ready.
// Ports: tdata[WIDTH], tvalid, tready.
interface streaming_fifo_param_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fifo_ptr_wrap.sv
// rtl/fifo_ptr_wrap.sv - modulo-DEPTH pointer incrementer
// Purpose: next-pointer value that wraps from DEPTH-1 to 0 by explicit compare,
//          so non-power-of-two depths work.
// Ports: ptr (current), inc (advance enable), ptr_next (combinational result).
module fifo_ptr_wrap #(
   parameter int DEPTH = 400,
   parameter int PW    = 9
) (
   input  logic [PW-1:0] ptr,
   input  logic          inc,
   output logic [PW-1:0] ptr_next
);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   always_comb begin
      ptr_next = ptr;
      if (inc) begin
         ptr_next = (ptr == LAST) ? '0 : ptr + 1'b1;
      end
   end
endmodule

// File: rtl/streaming_fifo_param.sv
// rtl/streaming_fifo_param.sv - parametrised first-word-fall-through stream FIFO
// Purpose: arbitrary-depth stream buffer with live occupancy, clearable high-water
//          mark, almost-full/almost-empty flags and synchronous flush.
// Ports: ap_clk, ap_rst (sync, active-high), flush, maxcount_clr,
//        in0_V (slave stream), out_V (master stream),
//        count, maxcount, almost_full, almost_empty (all registered).
module streaming_fifo_param
   import streaming_fifo_pkg::*;
#(
   parameter int  WIDTH     = 32,
   parameter int  DEPTH     = 400,
   parameter int  AFULL_TH  = DEPTH - 2,
   parameter int  AEMPTY_TH = 2,
   localparam int CW        = count_width(DEPTH)
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   input  logic                          flush,
   input  logic                          maxcount_clr,
   streaming_fifo_param_if.slave         in0_V,
   streaming_fifo_param_if.master        out_V,
   output logic [CW-1:0]                 count,
   output logic [CW-1:0]                 maxcount,
   output logic                          almost_full,
   output logic                          almost_empty
);
   localparam int            PW       = clog2_depth(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
   localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

   generate
      if (!thresholds_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
         $error("streaming_fifo_param: need DEPTH>=2 and 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
      end
   endgenerate

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next;
   logic [CW-1:0]    count_next, max_next;
   logic             in_ready, out_valid, push, pop;

   // Ready is a function of registered occupancy only, so a full FIFO refuses
   // a push even when a pop happens in the same cycle.
   assign in_ready     = ~ap_rst & (count != FULL_CNT);
   assign out_valid    = (count != '0);
   assign in0_V.tready = in_ready;
   assign out_V.tvalid = out_valid;
   assign out_V.tdata  = mem[rd_ptr];

   assign push = in0_V.tvalid & in_ready;
   assign pop  = out_valid & out_V.tready;

   fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr_wrap (
      .ptr      (wr_ptr),
      .inc      (push),
      .ptr_next (wr_next)
   );

   fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd_wrap (
      .ptr      (rd_ptr),
      .inc      (pop),
      .ptr_next (rd_next)
   );

   always_comb begin
      count_next = count;
      if (flush) begin
         count_next = '0;
      end else if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (pop && !push) begin
         count_next = count - 1'b1;
      end
   end

   // A flush drives count_next to zero, so max() keeps the old mark unless cleared.
   always_comb begin
      max_next = maxcount;
      if (maxcount_clr) begin
         max_next = count_next;
      end else if (count_next > maxcount) begin
         max_next = count_next;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         maxcount     <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= flush ? '0 : wr_next;
         rd_ptr       <= flush ? '0 : rd_next;
         count        <= count_next;
         maxcount     <= max_next;
         almost_full  <= (count_next >= AF_CNT);
         almost_empty <= (count_next <= AE_CNT);
      end
   end

   // Storage has no reset; validity is tracked by count alone.
   always_ff @(posedge ap_clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= in0_V.tdata;
      end
   end
endmodule
